fb_swap_ctrl: RTL and testbench

//  Double-buffered framebuffer controller between the gfx renderer and video scan-out.
//  - Renderer pixel writes (h, v, r, g, b, done) are queued and written into the back buffer.
//  - Scan-out reads the front buffer.
//  - Both share one single-port 128Kx8 RAM (bit 16 selects the buffer).
//  - Front/back buffers are swapped in vblank after a finished frame.
//  - The renderer is held off, through its vs input, until the swap has happened.

---
 rtl/fb_swap_ctrl_if.sv | 40 ++++
 rtl/fb_swap_ctrl.sv | 145 ++++++++++++++
 tb/tb_fb_swap_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_swap_ctrl_if.sv
// Renderer, scan-out and RAM-port signals of the framebuffer swap controller.
// slave = controller side, master = renderer / video timing / RAM side.
interface fb_swap_ctrl_if;
    logic [7:0]  pix_h;
    logic [7:0]  pix_v;
    logic [2:0]  pix_r;
    logic [2:0]  pix_g;
    logic [1:0]  pix_b;
    logic        pix_we;
    logic        frame_done;
    logic        render_hold;
    logic        ce_pix;
    logic [7:0]  scan_h;
    logic [7:0]  scan_v;
    logic        scan_active;
    logic        vid_vs;
    logic [16:0] fb_addr;
    logic [7:0]  fb_din;
    logic        fb_we;
    logic [7:0]  fb_dout;
    logic [2:0]  vid_r;
    logic [2:0]  vid_g;
    logic [1:0]  vid_b;
    logic        disp_buf;
    logic        overflow;

    modport slave (
        input  pix_h, pix_v, pix_r, pix_g, pix_b, pix_we, frame_done,
        input  ce_pix, scan_h, scan_v, scan_active, vid_vs, fb_dout,
        output render_hold, fb_addr, fb_din, fb_we,
        output vid_r, vid_g, vid_b, disp_buf, overflow
    );

    modport master (
        output pix_h, pix_v, pix_r, pix_g, pix_b, pix_we, frame_done,
        output ce_pix, scan_h, scan_v, scan_active, vid_vs, fb_dout,
        input  render_hold, fb_addr, fb_din, fb_we,
        input  vid_r, vid_g, vid_b, disp_buf, overflow
    );
endinterface

// File: rtl/fb_swap_ctrl.sv
// Double-buffered framebuffer controller: queues renderer writes into the back buffer,
// serves scan-out reads from the front buffer, and swaps buffers in vblank.
module fb_swap_ctrl #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    fb_swap_ctrl_if.slave bus
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        S_RENDER,
        S_PENDING,
        S_SWAP,
        S_RELEASE
    } state_t;

    logic [23:0]   r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [PW:0]   r_count;
    logic          r_overflow;
    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic [23:0]   w_head;
    logic [23:0]   w_entry;

    logic [16:0]   r_fb_addr;
    logic [7:0]    r_fb_din;
    logic          r_fb_we;
    logic [2:1]    r_vld_pipe;
    logic [2:1]    r_act_pipe;
    logic [7:0]    r_vid;

    state_t        r_state;
    logic          r_hold;
    logic          r_disp_buf;

    assign w_entry = {bus.pix_v, bus.pix_h, bus.pix_r, bus.pix_g, bus.pix_b};
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (PW+1)'(FIFO_DEPTH));
    // Scan-out owns the RAM port on ce_pix cycles; the queue only drains in the gaps.
    assign w_pop   = !bus.ce_pix && !w_empty;
    assign w_push  = bus.pix_we && (!w_full || w_pop);
    assign w_head  = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wptr] <= w_entry;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
            if (bus.pix_we && !w_push)
                r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fb_addr <= '0;
            r_fb_din  <= '0;
            r_fb_we   <= 1'b0;
        end else if (bus.ce_pix) begin
            r_fb_addr <= {r_disp_buf, bus.scan_v, bus.scan_h};
            r_fb_we   <= 1'b0;
        end else if (w_pop) begin
            // Uses the pre-toggle buffer index even on the swap edge.
            r_fb_addr <= {~r_disp_buf, w_head[23:16], w_head[15:8]};
            r_fb_din  <= w_head[7:0];
            r_fb_we   <= 1'b1;
        end else begin
            r_fb_we   <= 1'b0;
        end
    end

    // Read data is valid two edges after ce_pix: address register, then RAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld_pipe <= '0;
            r_act_pipe <= '0;
            r_vid      <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[1], bus.ce_pix};
            r_act_pipe <= {r_act_pipe[1], bus.scan_active};
            if (r_vld_pipe[2])
                r_vid <= r_act_pipe[2] ? bus.fb_dout : 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_RENDER;
            r_hold     <= 1'b0;
            r_disp_buf <= 1'b0;
        end else begin
            case (r_state)
                S_RENDER: begin
                    if (bus.frame_done) begin
                        r_state <= S_PENDING;
                        r_hold  <= 1'b1;
                    end
                end
                S_PENDING: begin
                    // A push this cycle would land after the swap, so wait it out.
                    if (bus.vid_vs && w_empty && !bus.pix_we) begin
                        r_state    <= S_SWAP;
                        r_disp_buf <= ~r_disp_buf;
                    end
                end
                S_SWAP: begin
                    r_state <= S_RELEASE;
                    r_hold  <= 1'b0;
                end
                default: begin
                    r_state <= S_RENDER;
                    r_hold  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fb_addr     = r_fb_addr;
    assign bus.fb_din      = r_fb_din;
    assign bus.fb_we       = r_fb_we;
    assign bus.vid_r       = r_vid[7:5];
    assign bus.vid_g       = r_vid[4:2];
    assign bus.vid_b       = r_vid[1:0];
    assign bus.disp_buf    = r_disp_buf;
    assign bus.overflow    = r_overflow;
    assign bus.render_hold = r_hold;
endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Self-checking bench for fb_swap_ctrl: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_fb_swap_ctrl;
    localparam int DEPTH = 4;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;

    fb_swap_ctrl_if bus ();

    fb_swap_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM model, plus a log of every write the controller issues.
    logic [7:0]  mem [0:131071];
    logic        pre_en;
    logic [16:0] pre_a;
    logic [7:0]  pre_d;
    logic [24:0] wlog [$];

    always @(posedge clk) begin
        if (pre_en)
            mem[pre_a] <= pre_d;
        else if (bus.fb_we)
            mem[bus.fb_addr] <= bus.fb_din;
        bus.fb_dout <= mem[bus.fb_addr];
        if (bus.fb_we)
            wlog.push_back({bus.fb_addr, bus.fb_din});
    end

    typedef struct {
        logic        ce;
        logic [7:0]  sh;
        logic [7:0]  sv;
        logic        we_in;
        logic [7:0]  h;
        logic [7:0]  v;
        logic [7:0]  rgb;
        logic        exp_we;
        logic [16:0] exp_addr;
        logic [7:0]  exp_din;
    } vec_t;

    vec_t tv [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.pix_we      = 1'b0;
        bus.frame_done  = 1'b0;
        bus.ce_pix      = 1'b0;
        bus.scan_active = 1'b0;
    endtask

    task automatic set_pix(input logic [7:0] h, input logic [7:0] v, input logic [7:0] rgb);
        bus.pix_h  = h;
        bus.pix_v  = v;
        bus.pix_r  = rgb[7:5];
        bus.pix_g  = rgb[4:2];
        bus.pix_b  = rgb[1:0];
        bus.pix_we = 1'b1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Reference model state (randomized phase)
    logic [23:0] q [$];
    logic [23:0] e;
    logic        m_disp, m_wait, m_ovf, m_we, popped;
    logic [16:0] m_addr;
    logic [7:0]  m_din;
    int          last_swap, sz;
    logic        r_ce, r_pw, r_fd, r_vs, prev_ce;
    logic [7:0]  r_h, r_v, r_rgb, r_sh, r_sv;

    initial begin
        n_chk = 0;
        n_err = 0;
        pre_en = 1'b0;
        pre_a = '0;
        pre_d = '0;
        reset = 1'b1;
        bus.pix_h = '0; bus.pix_v = '0; bus.pix_r = '0; bus.pix_g = '0; bus.pix_b = '0;
        bus.scan_h = '0; bus.scan_v = '0; bus.vid_vs = 1'b0;
        idle();

        // Reset state
        do_reset();
        chk("rst_fb_addr", 32'(bus.fb_addr), 32'h0);
        chk("rst_fb_din", 32'(bus.fb_din), 32'h0);
        chk("rst_fb_we", 32'(bus.fb_we), 32'h0);
        chk("rst_vid", 32'({bus.vid_r, bus.vid_g, bus.vid_b}), 32'h0);
        chk("rst_disp_buf", 32'(bus.disp_buf), 32'h0);
        chk("rst_overflow", 32'(bus.overflow), 32'h0);
        chk("rst_render_hold", 32'(bus.render_hold), 32'h0);

        // Arbitration table: each row is one cycle's inputs and the registered result
        tv[0] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'h12, 8'h34, 8'hA5, 1'b0, 17'h00000, 8'h00};
        tv[1] = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 17'h13412, 8'hA5};
        tv[2] = '{1'b1, 8'h05, 8'h07, 1'b1, 8'h01, 8'h02, 8'h33, 1'b0, 17'h00705, 8'hA5};
        tv[3] = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 17'h10201, 8'h33};
        tv[4] = '{1'b0, 8'h00, 8'h00, 1'b1, 8'hFF, 8'hFF, 8'hFF, 1'b0, 17'h10201, 8'h33};
        tv[5] = '{1'b1, 8'hAA, 8'h55, 1'b1, 8'h10, 8'h20, 8'h0F, 1'b0, 17'h055AA, 8'h33};
        tv[6] = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 17'h1FFFF, 8'hFF};
        tv[7] = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 17'h12010, 8'h0F};
        tv[8] = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 17'h12010, 8'h0F};
        for (int i = 0; i < 9; i++) begin
            idle();
            bus.ce_pix = tv[i].ce;
            bus.scan_h = tv[i].sh;
            bus.scan_v = tv[i].sv;
            if (tv[i].we_in)
                set_pix(tv[i].h, tv[i].v, tv[i].rgb);
            tick();
            chk($sformatf("tv%0d_fb_we", i), 32'(bus.fb_we), 32'(tv[i].exp_we));
            chk($sformatf("tv%0d_fb_addr", i), 32'(bus.fb_addr), 32'(tv[i].exp_addr));
            chk($sformatf("tv%0d_fb_din", i), 32'(bus.fb_din), 32'(tv[i].exp_din));
        end
        idle();

        // Read priority and video latency
        do_reset();
        pre_en = 1'b1; pre_a = 17'h00705; pre_d = 8'h5A;
        tick();
        pre_a = 17'h00706; pre_d = 8'hFF;
        tick();
        pre_en = 1'b0;
        set_pix(8'h01, 8'h01, 8'h11);
        tick();
        idle();
        bus.ce_pix = 1'b1; bus.scan_h = 8'h05; bus.scan_v = 8'h07; bus.scan_active = 1'b1;
        tick();
        chk("t2_read_we", 32'(bus.fb_we), 32'h0);
        chk("t2_read_addr", 32'(bus.fb_addr), 32'h00705);
        idle();
        tick();
        chk("t2_write_we", 32'(bus.fb_we), 32'h1);
        chk("t2_write_addr", 32'(bus.fb_addr), 32'h10101);
        chk("t2_vid_early", 32'({bus.vid_r, bus.vid_g, bus.vid_b}), 32'h0);
        tick();
        chk("t2_vid_r", 32'(bus.vid_r), 32'h2);
        chk("t2_vid_g", 32'(bus.vid_g), 32'h6);
        chk("t2_vid_b", 32'(bus.vid_b), 32'h2);
        bus.ce_pix = 1'b1; bus.scan_h = 8'h06; bus.scan_v = 8'h07; bus.scan_active = 1'b0;
        tick();
        idle();
        tick();
        chk("t2_vid_hold", 32'({bus.vid_r, bus.vid_g, bus.vid_b}), 32'h5A);
        tick();
        chk("t2_vid_blank", 32'({bus.vid_r, bus.vid_g, bus.vid_b}), 32'h0);

        // Overflow with scan-out holding the port
        do_reset();
        bus.ce_pix = 1'b1; bus.scan_h = 8'h00; bus.scan_v = 8'h00;
        for (int i = 0; i < 5; i++) begin
            set_pix(8'(i * 16 + 1), 8'(8'h40 + i), 8'(8'h10 + i));
            if (i == 4)
                chk("t3_no_ovf_at_4", 32'(bus.overflow), 32'h0);
            tick();
        end
        bus.pix_we = 1'b0;
        tick();
        chk("t3_overflow", 32'(bus.overflow), 32'h1);
        wlog.delete();
        bus.ce_pix = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        chk("t3_write_count", 32'(wlog.size()), 32'd4);
        for (int i = 0; i < 4 && i < wlog.size(); i++)
            chk($sformatf("t3_write%0d", i), 32'(wlog[i]),
                32'({1'b1, 8'(8'h40 + i), 8'(i * 16 + 1), 8'(8'h10 + i)}));

        // Reset while PENDING with queued writes (overflow still sticky from above)
        bus.ce_pix = 1'b1;
        set_pix(8'h21, 8'h22, 8'h23);
        tick();
        set_pix(8'h31, 8'h32, 8'h33);
        tick();
        bus.pix_we = 1'b0;
        bus.frame_done = 1'b1;
        tick();
        bus.frame_done = 1'b0;
        chk("t6_hold_pending", 32'(bus.render_hold), 32'h1);
        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
        wlog.delete();
        for (int i = 0; i < 6; i++) tick();
        chk("t6_no_writes", 32'(wlog.size()), 32'd0);
        chk("t6_render_hold", 32'(bus.render_hold), 32'h0);
        chk("t6_disp_buf", 32'(bus.disp_buf), 32'h0);
        chk("t6_overflow", 32'(bus.overflow), 32'h0);

        // Swap in vblank
        do_reset();
        bus.vid_vs = 1'b0;
        bus.frame_done = 1'b1;
        tick();
        bus.frame_done = 1'b0;
        chk("t4_hold", 32'(bus.render_hold), 32'h1);
        chk("t4_disp_before", 32'(bus.disp_buf), 32'h0);
        tick();
        tick();
        chk("t4_disp_wait", 32'(bus.disp_buf), 32'h0);
        chk("t4_hold_wait", 32'(bus.render_hold), 32'h1);
        bus.vid_vs = 1'b1;
        tick();
        chk("t4_disp_swapped", 32'(bus.disp_buf), 32'h1);
        chk("t4_hold_swap", 32'(bus.render_hold), 32'h1);
        tick();
        chk("t4_hold_release", 32'(bus.render_hold), 32'h0);
        chk("t4_disp_kept", 32'(bus.disp_buf), 32'h1);
        bus.vid_vs = 1'b0;

        // Drain gating: swap only after the last queued write reaches the back buffer
        begin
            int nw, bad, last_w, swap_at;
            nw = 0; bad = 0; last_w = -1; swap_at = -1;
            do_reset();
            bus.vid_vs = 1'b1;
            bus.ce_pix = 1'b1;
            for (int i = 0; i < 3; i++) begin
                set_pix(8'(8'h50 + i), 8'h60, 8'(8'h70 + i));
                tick();
            end
            bus.pix_we = 1'b0;
            bus.frame_done = 1'b1;
            tick();
            bus.frame_done = 1'b0;
            chk("t5_hold", 32'(bus.render_hold), 32'h1);
            for (int c = 0; c < 20; c++) begin
                bus.ce_pix = c[0];
                tick();
                if (bus.fb_we) begin
                    nw++;
                    last_w = c;
                    if (!bus.fb_addr[16]) bad++;
                end
                if (bus.disp_buf && swap_at < 0) swap_at = c;
            end
            idle();
            bus.vid_vs = 1'b0;
            chk("t5_write_count", 32'(nw), 32'd3);
            chk("t5_back_buffer", 32'(bad), 32'd0);
            chk("t5_swap_after_drain", 32'(swap_at), 32'(last_w + 1));
            chk("t5_hold_released", 32'(bus.render_hold), 32'h0);
        end

        // Randomized run against a queue model
        do_reset();
        q.delete();
        m_disp = 1'b0; m_wait = 1'b0; m_ovf = 1'b0; m_we = 1'b0;
        m_addr = '0; m_din = '0; last_swap = -10; prev_ce = 1'b0; r_vs = 1'b0;
        for (int c = 0; c < 600; c++) begin
            r_ce  = !prev_ce && ($urandom_range(0, 9) < 4);
            r_pw  = ($urandom_range(0, 9) < 4);
            r_fd  = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 19) == 0) r_vs = ~r_vs;
            r_h = 8'($urandom); r_v = 8'($urandom); r_rgb = 8'($urandom);
            r_sh = 8'($urandom); r_sv = 8'($urandom);
            idle();
            bus.ce_pix = r_ce; bus.scan_h = r_sh; bus.scan_v = r_sv;
            bus.scan_active = 1'($urandom);
            bus.vid_vs = r_vs; bus.frame_done = r_fd;
            if (r_pw) set_pix(r_h, r_v, r_rgb);

            sz = q.size();
            popped = 1'b0;
            if (r_ce) begin
                m_we = 1'b0;
                m_addr = {m_disp, r_sv, r_sh};
            end else if (sz > 0) begin
                e = q.pop_front();
                m_we = 1'b1;
                m_addr = {~m_disp, e[23:16], e[15:8]};
                m_din = e[7:0];
                popped = 1'b1;
            end else begin
                m_we = 1'b0;
            end
            if (r_pw) begin
                if (sz < DEPTH || popped) q.push_back({r_v, r_h, r_rgb});
                else m_ovf = 1'b1;
            end
            if (m_wait) begin
                if (r_vs && sz == 0 && !r_pw) begin
                    m_disp = ~m_disp;
                    m_wait = 1'b0;
                    last_swap = c;
                end
            end else if (r_fd && (c - last_swap) > 2) begin
                m_wait = 1'b1;
            end

            tick();
            chk("rnd_fb_we", 32'(bus.fb_we), 32'(m_we));
            chk("rnd_fb_addr", 32'(bus.fb_addr), 32'(m_addr));
            chk("rnd_fb_din", 32'(bus.fb_din), 32'(m_din));
            chk("rnd_render_hold", 32'(bus.render_hold), 32'(m_wait || (last_swap == c)));
            chk("rnd_disp_buf", 32'(bus.disp_buf), 32'(m_disp));
            chk("rnd_overflow", 32'(bus.overflow), 32'(m_ovf));
            prev_ce = r_ce;
        end
        idle();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
